sub64_arb: RTL

SUB64_ARB -- requirements
Module: sub64_arb

---
 rtl/sub64_arb_if.sv | 32 +++
 rtl/sub64_arb.sv | 116 +++++++++++
 2 files changed

// File: rtl/sub64_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : sub64_arb_if
// Description : Requester-side bus of the shared SUB64 arbiter. Collects the
//               per-requester request/operand vectors and the grant, response
//               and busy vectors returned to the requesters.
//               master : requester side (drives req_valid/req_a/req_b)
//               slave  : arbiter side   (drives req_gnt/rsp_valid/rsp_data/busy)
// Revision    : 1.0 - initial release
// ============================================================================
interface sub64_arb_if #(
    parameter int N_REQ = 4
) ();
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*64-1:0] req_a;
    logic [N_REQ*64-1:0] req_b;
    logic [N_REQ-1:0]    req_gnt;
    logic [N_REQ-1:0]    rsp_valid;
    logic [63:0]         rsp_data;
    logic [N_REQ-1:0]    busy;

    modport master (
        output req_valid, req_a, req_b,
        input  req_gnt, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_gnt, rsp_valid, rsp_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/sub64_arb.sv
`default_nettype none
// ============================================================================
// Module      : sub64_arb
// Description : Round-robin arbiter sharing one SUB64 subtractor among N_REQ
//               requesters. One operation issued per cycle, one outstanding
//               operation per requester; results are routed back by a tag
//               pipeline that tracks the SUB64 latency.
// Ports       : clk, rst_n        - clock, async active-low reset
//               bus (slave)       - requester bus (see sub64_arb_if)
//               sub_data_in_a/b   - registered operands to SUB64
//               sub_data_valid    - issue strobe to SUB64
//               sub_data_out      - SUB64 result (a-b mod 2^64)
// Revision    : 1.0 - initial release
// ============================================================================
module sub64_arb #(
    parameter int N_REQ   = 4,
    parameter int SUB_LAT = 1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    sub64_arb_if.slave       bus,
    output logic [63:0]      sub_data_in_a,
    output logic [63:0]      sub_data_in_b,
    output logic             sub_data_valid,
    input  wire logic [63:0] sub_data_out
);

    localparam int PW = $clog2(N_REQ);

    logic [PW-1:0]    r_rr_ptr;
    logic [N_REQ-1:0] r_busy;
    logic [N_REQ-1:0] r_rsp_valid;
    logic [63:0]      r_rsp_data;
    logic             r_tag_vld [0:SUB_LAT];
    logic [PW-1:0]    r_tag_idx [0:SUB_LAT];

    logic [N_REQ-1:0] w_elig;
    logic [N_REQ-1:0] w_gnt;
    logic [PW-1:0]    w_gnt_idx;
    logic             w_gnt_any;

    assign w_elig = bus.req_valid & ~r_busy;

    // Search eligible requesters starting at the round-robin pointer; the
    // first hit in wrap-around order wins.
    always_comb begin
        int j;
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_gnt_any = 1'b0;
        j         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(r_rr_ptr) + k) % N_REQ;
            if (!w_gnt_any && w_elig[j]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = PW'(j);
            end
        end
        if (w_gnt_any) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end
    end

    // Grant is the only combinational output; held low while in reset.
    assign bus.req_gnt   = rst_n ? w_gnt : '0;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.busy      = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr       <= '0;
            r_busy         <= '0;
            r_rsp_valid    <= '0;
            r_rsp_data     <= '0;
            sub_data_valid <= 1'b0;
            sub_data_in_a  <= '0;
            sub_data_in_b  <= '0;
            for (int s = 0; s <= SUB_LAT; s++) begin
                r_tag_vld[s] <= 1'b0;
                r_tag_idx[s] <= '0;
            end
        end else begin
            // Issue register: operands only move on a grant, so they hold
            // their last value between operations.
            sub_data_valid <= w_gnt_any;
            if (w_gnt_any) begin
                sub_data_in_a <= bus.req_a[w_gnt_idx*64 +: 64];
                sub_data_in_b <= bus.req_b[w_gnt_idx*64 +: 64];
                r_rr_ptr      <= (w_gnt_idx == PW'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
            end

            // Stage 0 lines up with sub_data_valid; the last stage lines up
            // with the SUB64 result for that operation.
            r_tag_vld[0] <= w_gnt_any;
            r_tag_idx[0] <= w_gnt_idx;
            for (int s = 1; s <= SUB_LAT; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_idx[s] <= r_tag_idx[s-1];
            end

            if (r_tag_vld[SUB_LAT]) begin
                r_rsp_valid <= N_REQ'(1) << r_tag_idx[SUB_LAT];
                r_rsp_data  <= sub_data_out;
            end else begin
                r_rsp_valid <= '0;
            end

            // busy stays high through the response cycle so a re-request made
            // then is only eligible from the following cycle.
            r_busy <= (r_busy | w_gnt) & ~r_rsp_valid;
        end
    end

endmodule
`default_nettype wire
